uram_row_arbiter: RTL

//  Row-level arbiter and shared-memory (URAM) port mux for NUM_CORES RISCV_core_top instances.

---
 rtl/uram_row_arbiter_pkg.sv | 18 +
 rtl/uram_row_arbiter_rr_priority_picker.sv | 45 ++++
 rtl/uram_row_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uram_row_arbiter_pkg.sv
// uram_row_arbiter_pkg: shared state type, row default and width helper
// for the URAM row arbiter and its round-robin picker.
package uram_row_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int NUM_CORES_PER_ROW = 4;

    // Index width for n channels; a single channel still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uram_row_arbiter_rr_priority_picker.sv
// rr_priority_picker: purely combinational round-robin find-first.
// Rotates the request vector so the pointer position becomes bit 0,
// takes the lowest set bit, then maps the index back.
module rr_priority_picker
    import uram_row_arbiter_pkg::*;
#(
    parameter int N  = NUM_CORES_PER_ROW,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    logic [N-1:0]  req_rot;
    logic [PW-1:0] src_idx;
    logic          hit;
    int            sel_rot;
    int            sel_abs;

    // Rotate, find first requester at or after the pointer, un-rotate.
    always_comb begin
        req_rot = '0;
        src_idx = '0;
        hit     = 1'b0;
        sel_rot = 0;
        for (int i = 0; i < N; i++) begin
            src_idx    = PW'((i + int'(i_ptr)) % N);
            req_rot[i] = i_req[src_idx];
        end
        for (int i = 0; i < N; i++) begin
            if (req_rot[i] && !hit) begin
                hit     = 1'b1;
                sel_rot = i;
            end
        end
        sel_abs  = (sel_rot + int'(i_ptr)) % N;
        o_valid  = hit;
        o_idx    = hit ? PW'(sel_abs) : '0;
        o_onehot = hit ? (N'(1) << sel_abs) : '0;
    end

endmodule

// File: rtl/uram_row_arbiter.sv
// uram_row_arbiter: round-robin row arbiter and URAM port mux for a row of
// cores. One owner at a time; its URAM access is forwarded through one
// register stage, masked to zero whenever nobody holds the grant.
// Optional feature macro: URAM_ARB_TIMEOUT_EN (forced revoke after
// MAX_HOLD_CYCLES grant cycles, sticky o_timeout_err).
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ARB_IDLE     | no owner; pick first requester at/after rr_ptr
// ARB_GRANT    | owner holds grant while its req or lock is high
// ARB_RELEASE  | one quiet cycle, grant and URAM port at 0; advance rr_ptr
module uram_row_arbiter
    import uram_row_arbiter_pkg::*;
#(
    parameter int NUM_CORES       = NUM_CORES_PER_ROW,
    parameter int ADDR_W          = 12,
    parameter int DATA_W          = 32,
    parameter int MAX_HOLD_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          i_core_req,
    input  logic [NUM_CORES-1:0]          i_core_locked,
    output logic [NUM_CORES-1:0]          o_core_grant,
    input  logic [NUM_CORES-1:0]          i_uram_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_uram_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_uram_wr_data,
    input  logic [NUM_CORES-1:0]          i_uram_wr_en,
    output logic                          o_uram_en,
    output logic [ADDR_W-1:0]             o_uram_addr,
    output logic [DATA_W-1:0]             o_uram_wr_data,
    output logic                          o_uram_wr_en,
    input  logic                          i_drain_done,
    output logic                          o_uram_emptied,
    output logic                          o_timeout_err
);

    localparam int PTR_W = ptr_width(NUM_CORES);

    arb_state_t           state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 pick_valid;
    logic [NUM_CORES-1:0] pick_onehot;
    logic [PTR_W-1:0]     pick_idx;

    logic                 owner_hold;
    logic                 owner_keep;
    logic                 force_release;
    logic                 grant_rise;

    logic                 uram_en_q, uram_en_d;
    logic                 uram_wr_en_q, uram_wr_en_d;
    logic [ADDR_W-1:0]    uram_addr_q, uram_addr_d;
    logic [DATA_W-1:0]    uram_wr_data_q, uram_wr_data_d;
    logic                 emptied_q, emptied_d;

    logic [ADDR_W-1:0]    core_addr [NUM_CORES];
    logic [DATA_W-1:0]    core_data [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
        assign core_addr[k] = i_uram_addr[k*ADDR_W +: ADDR_W];
        assign core_data[k] = i_uram_wr_data[k*DATA_W +: DATA_W];
    end

    rr_priority_picker #(
        .N  (NUM_CORES),
        .PW (PTR_W)
    ) u_picker (
        .i_req    (i_core_req),
        .i_ptr    (rr_ptr_q),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_valid  (pick_valid)
    );

    assign owner_hold = i_core_req[owner_q] | i_core_locked[owner_q];

`ifdef URAM_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_next;
    logic              timeout_err_q, timeout_err_d;

    // The counter reaches the limit on the same edge that revokes, so the
    // grant is visible for exactly MAX_HOLD_CYCLES cycles.
    assign hold_next     = hold_cnt_q + HOLD_W'(1);
    assign force_release = (state_q == ARB_GRANT) && owner_hold &&
                           (hold_next == HOLD_W'(MAX_HOLD_CYCLES));

    // Hold counter next-state and sticky timeout flag.
    always_comb begin
        hold_cnt_d    = hold_cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == ARB_GRANT) begin
            hold_cnt_d = hold_next;
        end else begin
            hold_cnt_d = '0;
        end
        if (force_release) begin
            timeout_err_d = 1'b1;
        end
    end

    // Hold counter and timeout flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign o_timeout_err = timeout_err_q;
`else
    logic unused_hold_cfg;

    assign unused_hold_cfg = (MAX_HOLD_CYCLES > 0);
    assign force_release   = 1'b0;
    assign o_timeout_err   = 1'b0;
`endif

    // Arbitration FSM next-state: grant, owner and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!owner_hold || force_release) begin
                    grant_d = '0;
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                grant_d  = '0;
                rr_ptr_d = (owner_q == PTR_W'(NUM_CORES - 1)) ? '0 : owner_q + PTR_W'(1);
                state_d  = ARB_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM state, grant, owner and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Only an owner that keeps its grant this cycle reaches the port; the
    // cycle in which the grant drops registers zeros, which keeps the
    // URAM port quiet during RELEASE.
    assign owner_keep = grant_q[owner_q] & grant_d[owner_q];

    // URAM mux: select owner's access, masked by the kept grant.
    always_comb begin
        uram_en_d      = i_uram_en[owner_q] & owner_keep;
        uram_wr_en_d   = i_uram_wr_en[owner_q] & owner_keep;
        uram_addr_d    = core_addr[owner_q] & {ADDR_W{owner_keep}};
        uram_wr_data_d = core_data[owner_q] & {DATA_W{owner_keep}};
    end

    // URAM output register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uram_en_q      <= 1'b0;
            uram_wr_en_q   <= 1'b0;
            uram_addr_q    <= '0;
            uram_wr_data_q <= '0;
        end else begin
            uram_en_q      <= uram_en_d;
            uram_wr_en_q   <= uram_wr_en_d;
            uram_addr_q    <= uram_addr_d;
            uram_wr_data_q <= uram_wr_data_d;
        end
    end

    // Emptied flag: set by drain-done, cleared when a grant first appears;
    // set wins if both happen on the same edge.
    assign grant_rise = ~(|grant_q) & (|grant_d);
    assign emptied_d  = i_drain_done | (emptied_q & ~grant_rise);

    // Emptied flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            emptied_q <= 1'b0;
        end else begin
            emptied_q <= emptied_d;
        end
    end

    assign o_core_grant   = grant_q;
    assign o_uram_en      = uram_en_q;
    assign o_uram_addr    = uram_addr_q;
    assign o_uram_wr_data = uram_wr_data_q;
    assign o_uram_wr_en   = uram_wr_en_q;
    assign o_uram_emptied = emptied_q;

endmodule
